// File: rtl/sgnext_pkg.sv
// Shared constants and helpers for the sign/zero-extension pipeline.
package sgnext_pkg;

  localparam logic MODE_ZEXT = 1'b0;
  localparam logic MODE_SEXT = 1'b1;

  localparam int DEF_N = 12;
  localparam int DEF_M = 32;

  // A field length is usable only if it names at least one bit and fits the container.
  function automatic logic len_legal(input int len, input int n);
    return (len >= 1) && (len <= n);
  endfunction

endpackage

// File: rtl/sgnext_stage.sv
// One valid/ready register slice of parametrised width.
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both high. A producer holds valid and data steady until that
// edge. This slice is ready whenever it is empty or its word leaves on the
// same edge, so a full slice still sustains one word per cycle.
module sgnext_stage #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign o_ready = !valid_q || i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  // Load a new word when the slot is free or being drained; otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (o_ready) begin
      valid_q <= i_valid;
      if (i_valid) data_q <= i_data;
    end
  end

endmodule

// File: rtl/sgnext_pipe.sv
// Two-stage pipeline that zero- or sign-extends a variable-length field.
// S1 registers the raw request, the extension is computed combinationally
// from S1, and S2 registers the result, so i_x never reaches o_y in one cycle.
module sgnext_pipe
  import sgnext_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int M  = DEF_M,
  parameter int LW = $clog2(N + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [N-1:0]  i_x,
  input  logic [LW-1:0] i_len,
  input  logic          i_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [M-1:0]  o_y,
  output logic          o_err,
  output logic [31:0]   o_cnt
);

  localparam int S1W = N + LW + 1;
  localparam int S2W = M + 1;

  logic           run_q;
  logic           s1_ready, s1_valid, s2_ready;
  logic [S1W-1:0] s1_data;
  logic [S2W-1:0] s2_data;
  logic [N-1:0]   s1_x;
  logic [LW-1:0]  s1_len;
  logic           s1_mode;
  int             len_i;
  logic [M-1:0]   xe;
  logic           msb, sbit;
  logic [M-1:0]   ext_y;
  logic           ext_err;
  logic [31:0]    cnt_q;

  // Holds the input side closed during reset and opens it on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign o_ready = s1_ready & run_q;

  sgnext_stage #(.W(S1W)) u_s1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid & run_q),
    .o_ready (s1_ready),
    .i_data  ({i_x, i_len, i_mode}),
    .o_valid (s1_valid),
    .i_ready (s2_ready),
    .o_data  (s1_data)
  );

  assign s1_x    = s1_data[S1W-1 -: N];
  assign s1_len  = s1_data[LW:1];
  assign s1_mode = s1_data[0];
  assign len_i   = int'(s1_len);

  // Keep the low len bits, fill the rest with zero or the field's top bit;
  // an illegal length yields zero with the error flag.
  always_comb begin
    xe          = '0;
    xe[N-1:0]   = s1_x;
    msb         = 1'b0;
    sbit        = 1'b0;
    ext_y       = '0;
    ext_err     = 1'b0;
    if (!len_legal(len_i, N)) begin
      ext_err = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i == len_i - 1) msb = s1_x[i];
      end
      case (s1_mode)
        MODE_ZEXT: sbit = 1'b0;
        MODE_SEXT: sbit = msb;
        default:   sbit = 1'b0;
      endcase
      for (int i = 0; i < M; i++) begin
        ext_y[i] = (i < len_i) ? xe[i] : sbit;
      end
    end
  end

  sgnext_stage #(.W(S2W)) u_s2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (s1_valid),
    .o_ready (s2_ready),
    .i_data  ({ext_err, ext_y}),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (s2_data)
  );

  assign o_y   = s2_data[M-1:0];
  assign o_err = s2_data[M];
  assign o_cnt = cnt_q;

  // Counts delivered results, error results included; wraps naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              cnt_q <= '0;
    else if (o_valid && i_ready) cnt_q <= cnt_q + 32'd1;
  end

endmodule

// File: tb/tb_sgnext_pipe.sv
// Bench for sgnext_pipe: directed vector table, stall and reset sequences,
// full 12-bit sign-extension sweep and randomized valid/ready traffic.
module tb_sgnext_pipe;

  localparam int N  = 12;
  localparam int M  = 32;
  localparam int LW = 4;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [N-1:0]  i_x;
  logic [LW-1:0] i_len;
  logic          i_mode;
  logic          o_valid;
  logic          i_ready;
  logic [M-1:0]  o_y;
  logic          o_err;
  logic [31:0]   o_cnt;

  sgnext_pipe #(.N(N), .M(M), .LW(LW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .i_len   (i_len),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_y     (o_y),
    .o_err   (o_err),
    .o_cnt   (o_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [M:0] exp_q[$];
  int         stamp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         n_in     = 0;
  int         n_out    = 0;
  int         n_block  = 0;
  logic       lat_chk  = 1'b0;
  logic       stall_prev = 1'b0;
  logic [M:0] held     = '0;
  logic       saw_busy = 1'b0;

  typedef struct {
    logic [N-1:0]  x;
    logic [LW-1:0] len;
    logic          mode;
    logic [M-1:0]  y;
    logic          err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: keep the low len bits as a number, then reinterpret it as a
  // len-bit two's complement value when sign-extending.
  function automatic logic [M:0] ref_model(input logic [N-1:0] x, input int len, input logic md);
    longint v, p;
    logic [63:0] r;
    if (len < 1 || len > N) return {1'b1, {M{1'b0}}};
    p = 64'sd1 <<< len;
    v = longint'({52'd0, x}) % p;
    if (md && (v >= p / 2)) v = v - p;
    r = v;
    return {1'b0, r[M-1:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input logic [N-1:0] x, input logic [LW-1:0] len,
                             input logic md, input logic rdy, input logic [M:0] exp);
    logic [M:0] e;
    int st;
    i_valid = v; i_x = x; i_len = len; i_mode = md; i_ready = rdy;
    #1;
    if (stall_prev) begin
      check("stall_valid", {63'd0, o_valid}, 64'd1);
      check("stall_hold", {31'd0, o_err, o_y}, {31'd0, held});
    end
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {63'd0, o_valid}, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        st = stamp_q.pop_front();
        check("result", {31'd0, o_err, o_y}, {31'd0, e});
        if (lat_chk) check("latency", 64'(cyc - st), 64'd2);
        n_out++;
      end
    end
    if (i_valid && o_ready) begin
      exp_q.push_back(exp);
      stamp_q.push_back(cyc);
      n_in++;
    end else if (i_valid) begin
      n_block++;
    end
    if (!o_ready) saw_busy = 1'b1;
    stall_prev = o_valid && !i_ready;
    held = {o_err, o_y};
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [N-1:0]  rx;
    logic [LW-1:0] rl;
    logic          rm, rv, rr;
    int            base_in, base_out;

    rst_n = 1'b0; i_valid = 1'b0; i_x = '0; i_len = '0; i_mode = 1'b0; i_ready = 1'b0;

    vecs[0]  = '{12'hABC, 4'd8,  1'b1, 32'hFFFFFFBC, 1'b0};
    vecs[1]  = '{12'hABC, 4'd8,  1'b0, 32'h000000BC, 1'b0};
    vecs[2]  = '{12'hABC, 4'd4,  1'b1, 32'hFFFFFFFC, 1'b0};
    vecs[3]  = '{12'hFFF, 4'd0,  1'b1, 32'h00000000, 1'b1};
    vecs[4]  = '{12'hFFF, 4'd13, 1'b1, 32'h00000000, 1'b1};
    vecs[5]  = '{12'hFFF, 4'd12, 1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{12'h7FF, 4'd12, 1'b1, 32'h000007FF, 1'b0};
    vecs[7]  = '{12'h800, 4'd12, 1'b0, 32'h00000800, 1'b0};
    vecs[8]  = '{12'h001, 4'd1,  1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{12'hFFE, 4'd1,  1'b1, 32'h00000000, 1'b0};
    vecs[10] = '{12'h0F0, 4'd15, 1'b0, 32'h00000000, 1'b1};
    vecs[11] = '{12'h5A5, 4'd7,  1'b0, 32'h00000025, 1'b0};

    // Reset state, observed without any clock edge.
    #1;
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_o_y", {32'd0, o_y}, 64'd0);
    check("rst_o_err", {63'd0, o_err}, 64'd0);
    check("rst_o_cnt", {32'd0, o_cnt}, 64'd0);
    check("rst_o_ready", {63'd0, o_ready}, 64'd0);
    #11 rst_n = 1'b1;
    #1 check("ready_before_edge", {63'd0, o_ready}, 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {63'd0, o_ready}, 64'd1);

    // Directed table, back to back.
    for (int i = 0; i < 12; i++)
      drive_cycle(1'b1, vecs[i].x, vecs[i].len, vecs[i].mode, 1'b1, {vecs[i].err, vecs[i].y});
    drain();

    // Five words with downstream stalled for cycles 3..7.
    base_in = n_in; base_out = n_out; saw_busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rx = N'(16'h111 * (c + 1));
      rv = (n_in - base_in) < 5;
      rr = !(c >= 3 && c <= 7);
      drive_cycle(rv, rx, 4'd12, 1'b1, rr, ref_model(rx, 12, 1'b1));
    end
    check("stall_saw_busy", {63'd0, saw_busy}, 64'd1);
    check("stall_delivered", 64'(n_out - base_out), 64'd5);
    check("stall_cnt", {32'd0, o_cnt}, 64'(n_out));

    // Full 12-bit sweep, sign extension, one word per cycle.
    lat_chk = 1'b1; n_block = 0; base_out = n_out;
    for (int xv = -2048; xv <= 2047; xv++) begin
      rx = xv[N-1:0];
      drive_cycle(1'b1, rx, 4'd12, 1'b1, 1'b1, {1'b0, xv});
    end
    drain();
    lat_chk = 1'b0;
    check("sweep_no_block", 64'(n_block), 64'd0);
    check("sweep_count", 64'(n_out - base_out), 64'd4096);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 10000; ) begin
      rx = N'($urandom_range(0, 4095));
      rl = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(1, 12));
      rm = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      base_in = n_in;
      drive_cycle(rv, rx, rl, rm, rr, ref_model(rx, int'(rl), rm));
      if (n_in != base_in) i++;
    end
    drain();
    check("rand_in_eq_out", 64'(n_in), 64'(n_out));
    check("rand_cnt", {32'd0, o_cnt}, 64'(n_out));

    // Reset between edges with two words held in the pipe.
    drive_cycle(1'b1, 12'h9AB, 4'd12, 1'b1, 1'b0, ref_model(12'h9AB, 12, 1'b1));
    drive_cycle(1'b1, 12'h123, 4'd12, 1'b1, 1'b0, ref_model(12'h123, 12, 1'b1));
    i_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    check("midrst_o_y", {32'd0, o_y}, 64'd0);
    check("midrst_o_cnt", {32'd0, o_cnt}, 64'd0);
    check("midrst_o_ready", {63'd0, o_ready}, 64'd0);
    exp_q.delete(); stamp_q.delete();
    n_in = 0; n_out = 0; stall_prev = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_back", {63'd0, o_ready}, 64'd1);
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0);
    check("midrst_no_stale", 64'(n_out), 64'd0);
    for (int k = 0; k < 3; k++) begin
      rx = N'(12'h0C3 + k);
      drive_cycle(1'b1, rx, 4'd6, 1'b1, 1'b1, ref_model(rx, 6, 1'b1));
    end
    drain();
    check("post_rst_cnt", {32'd0, o_cnt}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
